// File: rtl/addsub_pkg.sv
// Shared helpers for the pipelined add/subtract unit: chunk sizing and
// parameter legality checks used at elaboration time.
package addsub_pkg;

  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Falls back to the full width for illegal pairs so elaboration can still
  // reach the explicit error in the top level.
  function automatic int chunk_width(input int width, input int stages);
    return params_ok(width, stages) ? (width / stages) : width;
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational C-bit ripple-carry slice built from full-adder cells; also
// exposes the carry into its top bit so the last slice can flag overflow.
module rca_chunk #(
  parameter int C = 4
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         cin,
  output logic [C-1:0] s,
  output logic         cout,
  output logic         c_top
);

  logic [C:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < C; gi++) begin : g_fa
    assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | ((a[gi] ^ b[gi]) & c[gi]);
  end

  assign cout  = c[C];
  assign c_top = c[C-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/subtract: one chunk-wide ripple per stage,
// carry registered between chunks, valid/ready on both sides with a global stall.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int C = chunk_width(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic             advance;
  logic             valid_src   [STAGES];
  logic             cin_src     [STAGES];
  logic [WIDTH-1:0] a_src       [STAGES];
  logic [WIDTH-1:0] b_src       [STAGES];
  logic [WIDTH-1:0] sum_src     [STAGES];
  logic [WIDTH-1:0] sum_next    [STAGES];
  logic [C-1:0]     chunk_sum   [STAGES];
  logic             chunk_cout  [STAGES];
  logic             chunk_ctop  [STAGES];

  logic             valid_reg   [STAGES];
  logic [WIDTH-1:0] sum_reg     [STAGES];
  logic [WIDTH-1:0] a_reg       [STAGES];
  logic [WIDTH-1:0] b_reg       [STAGES];
  logic             carry_reg   [STAGES];
  logic             msb_carry_reg;

  assign advance  = !valid_reg[STAGES-1] || out_ready;
  assign in_ready = advance;

  // Operand remainders travel pre-shifted, so every stage's chunk sits at [C-1:0].
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign valid_src[gi] = in_valid;
      assign cin_src[gi]   = sub;
      assign a_src[gi]     = a;
      assign b_src[gi]     = b ^ {WIDTH{sub}};
      assign sum_src[gi]   = '0;
    end else begin : g_later
      assign valid_src[gi] = valid_reg[gi-1];
      assign cin_src[gi]   = carry_reg[gi-1];
      assign a_src[gi]     = a_reg[gi-1];
      assign b_src[gi]     = b_reg[gi-1];
      assign sum_src[gi]   = sum_reg[gi-1];
    end

    rca_chunk #(.C(C)) u_chunk (
      .a     (a_src[gi][C-1:0]),
      .b     (b_src[gi][C-1:0]),
      .cin   (cin_src[gi]),
      .s     (chunk_sum[gi]),
      .cout  (chunk_cout[gi]),
      .c_top (chunk_ctop[gi])
    );

    assign sum_next[gi] = sum_src[gi] | (WIDTH'(chunk_sum[gi]) << (gi * C));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_reg[k] <= 1'b0;
        sum_reg[k]   <= '0;
        a_reg[k]     <= '0;
        b_reg[k]     <= '0;
        carry_reg[k] <= 1'b0;
      end
      msb_carry_reg <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_reg[k] <= valid_src[k];
        sum_reg[k]   <= sum_next[k];
        a_reg[k]     <= a_src[k] >> C;
        b_reg[k]     <= b_src[k] >> C;
        carry_reg[k] <= chunk_cout[k];
      end
      msb_carry_reg <= chunk_ctop[STAGES-1];
    end
  end

  assign out_valid = valid_reg[STAGES-1];
  assign sum       = sum_reg[STAGES-1];
  assign cout      = carry_reg[STAGES-1];
  assign ovf       = carry_reg[STAGES-1] ^ msb_carry_reg;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: four instances (STAGES 1,2,4,8) share stimulus;
// an arithmetic reference model feeds per-instance scoreboards checked every cycle.
module tb_pipelined_addsub;

  localparam int WIDTH = 8;
  localparam int ND    = 4;
  localparam int MAIN  = 1;
  localparam int FD    = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       sub = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic       in_ready_w  [ND];
  logic       out_valid_w [ND];
  logic       cout_w      [ND];
  logic       ovf_w       [ND];
  logic [7:0] sum_w       [ND];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  function automatic int stages_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : (d == 2) ? 4 : 8;
  endfunction

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    pipelined_addsub #(.WIDTH(WIDTH), .STAGES(stages_of(gi))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[gi]),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid_w[gi]),
      .out_ready (out_ready),
      .sum       (sum_w[gi]),
      .cout      (cout_w[gi]),
      .ovf       (ovf_w[gi])
    );
  end

  // Reference: plain unsigned/signed arithmetic, returns {cout, ovf, sum}.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [8:0] r;
    logic       c;
    logic       v;
    if (!s) begin
      r = {1'b0, x} + {1'b0, y};
      c = r[8];
      v = (x[7] == y[7]) && (r[7] != x[7]);
    end else begin
      r = {1'b0, x} - {1'b0, y};
      c = (x >= y);
      v = (x[7] != y[7]) && (r[7] != x[7]);
    end
    return {c, v, r[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Per-instance scoreboard state
  logic [9:0] fifo     [ND][FD];
  int         wr       [ND];
  int         rd       [ND];
  int         res_cnt  [ND];
  bit         held     [ND];
  logic [9:0] held_val [ND];
  logic [7:0] got_main [$];

  initial begin
    for (int d = 0; d < ND; d++) begin
      wr[d] = 0; rd[d] = 0; res_cnt[d] = 0; held[d] = 1'b0; held_val[d] = '0;
    end
  end

  // Single compare process: inputs and outputs are both settled at the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        rd[d] = 0; wr[d] = 0; held[d] = 1'b0;
      end else begin
        if (held[d]) begin
          check($sformatf("S%0d hold", stages_of(d)),
                {out_valid_w[d], cout_w[d], ovf_w[d], sum_w[d]}, {1'b1, held_val[d]});
        end
        if (out_valid_w[d]) begin
          if (out_ready) begin
            held[d] = 1'b0;
            if (rd[d] == wr[d]) begin
              check($sformatf("S%0d unexpected result", stages_of(d)), 32'd1, 32'd0);
            end else begin
              check($sformatf("S%0d result #%0d", stages_of(d), rd[d]),
                    {cout_w[d], ovf_w[d], sum_w[d]}, fifo[d][rd[d] % FD]);
              rd[d]++;
              res_cnt[d]++;
              if (d == MAIN) got_main.push_back(sum_w[d]);
            end
          end else begin
            held[d]     = 1'b1;
            held_val[d] = {cout_w[d], ovf_w[d], sum_w[d]};
          end
        end else begin
          held[d] = 1'b0;
        end
        if (in_valid && in_ready_w[d]) begin
          fifo[d][wr[d] % FD] = model(a, b, sub);
          wr[d]++;
        end
      end
    end
  end

  // One operand beat on the main instance, literal checks at each pipeline step.
  task automatic directed(input string nm, input logic [7:0] x, input logic [7:0] y, input logic s,
                          input logic [7:0] es, input logic ec, input logic ev);
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y; sub = s;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = ~s;
    check({nm, " out_valid after accept"}, 32'(out_valid_w[MAIN]), 32'd0);
    @(posedge clk); #1;
    check({nm, " out_valid"}, 32'(out_valid_w[MAIN]), 32'd1);
    check({nm, " sum"},  32'(sum_w[MAIN]),  32'(es));
    check({nm, " cout"}, 32'(cout_w[MAIN]), 32'(ec));
    check({nm, " ovf"},  32'(ovf_w[MAIN]),  32'(ev));
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps   [ND];
    int base   [ND];
    int notready;
    int ghost;

    #1 rst = 1'b1;
    #1;
    check("reset out_valid", 32'(out_valid_w[MAIN]), 32'd0);
    check("reset sum",       32'(sum_w[MAIN]),       32'd0);
    check("reset cout",      32'(cout_w[MAIN]),      32'd0);
    check("reset ovf",       32'(ovf_w[MAIN]),       32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("in_ready after reset", 32'(in_ready_w[MAIN]), 32'd1);

    // Pin the reference model against hand-computed results
    check("model 7F+01", 32'(model(8'h7F, 8'h01, 1'b0)), 32'({1'b0, 1'b1, 8'h80}));
    check("model FF+01", 32'(model(8'hFF, 8'h01, 1'b0)), 32'({1'b1, 1'b0, 8'h00}));
    check("model 05-07", 32'(model(8'h05, 8'h07, 1'b1)), 32'({1'b0, 1'b0, 8'hFE}));
    check("model 80-01", 32'(model(8'h80, 8'h01, 1'b1)), 32'({1'b1, 1'b1, 8'h7F}));

    directed("add 7F+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    directed("add FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    directed("sub 05-07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    directed("sub 80-01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Backpressure: four beats, consumer stalls three cycles at the first result
    got_main.delete();
    fork
      begin
        bit acc;
        for (int i = 0; i < 4; i++) begin
          in_valid = 1'b1; a = 8'(i + 1); b = 8'(i + 1); sub = 1'b0;
          acc = 1'b0;
          for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready_w[MAIN];
            @(posedge clk); #1;
          end
          if (!acc) check("backpressure accept timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
      end
      begin
        bit found;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
          @(posedge clk); #1;
          found = out_valid_w[MAIN];
        end
        check("backpressure first out_valid", 32'(found), 32'd1);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("in_ready during stall", 32'(in_ready_w[MAIN]), 32'd0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    check("backpressure result count", 32'(got_main.size()), 32'd4);
    if (got_main.size() == 4) begin
      check("backpressure result 0", 32'(got_main[0]), 32'h02);
      check("backpressure result 1", 32'(got_main[1]), 32'h04);
      check("backpressure result 2", 32'(got_main[2]), 32'h06);
      check("backpressure result 3", 32'(got_main[3]), 32'h08);
    end

    // Reset with two beats in flight
    @(posedge clk); #1;
    in_valid = 1'b1; a = 8'h11; b = 8'h22; sub = 1'b0;
    @(posedge clk); #1;
    a = 8'h33; b = 8'h44; sub = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre-reset out_valid", 32'(out_valid_w[MAIN]), 32'd1);
    rst = 1'b1;
    #1;
    check("mid-flight reset out_valid", 32'(out_valid_w[MAIN]), 32'd0);
    check("mid-flight reset sum",       32'(sum_w[MAIN]),       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ghost = 0;
    repeat (10) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) if (out_valid_w[d]) ghost++;
    end
    check("results after reset", 32'(ghost), 32'd0);
    check("in_ready after mid-flight reset", 32'(in_ready_w[MAIN]), 32'd1);

    // Full-rate random stream on all four depths
    @(posedge clk); #1;
    notready = 0;
    for (int d = 0; d < ND; d++) begin
      gaps[d] = 0;
      base[d] = res_cnt[d];
    end
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      @(negedge clk);
      if (!in_ready_w[MAIN]) notready++;
      if (i >= 8) for (int d = 0; d < ND; d++) if (!out_valid_w[d]) gaps[d]++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("stream in_ready drops", 32'(notready), 32'd0);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("S%0d stream gaps", stages_of(d)), 32'(gaps[d]), 32'd0);
      check($sformatf("S%0d stream result count", stages_of(d)), 32'(res_cnt[d] - base[d]), 32'd1000);
      check($sformatf("S%0d leftover expected", stages_of(d)), 32'(wr[d] - rd[d]), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
